// File: rtl/esd_hb_pkg.sv
// Shared types and elaboration-time helpers for the ESD heartbeat master.
package esd_hb_pkg;

  // FSM state encoding; values are visible on state_o.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_STARVE   = 3'd2,
    ST_SHUTDOWN = 3'd3,
    ST_ACK_LOW  = 3'd4,
    ST_ACK_WAIT = 3'd5
  } hb_state_e;

  localparam int STATE_W = 3;

  // Ceiling log2, used to size counters.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Milliseconds to clock cycles, never less than one cycle.
  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    int c;
    c = (clk_hz / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

  // States in which the watchdog kick generator runs.
  function automatic logic kick_active(input hb_state_e s);
    return (s == ST_RUN) || (s == ST_ACK_WAIT);
  endfunction

endpackage

// File: rtl/esd_heartbeat_master_deadline.sv
// Per-task alive deadline counter: flags a miss when TASK_CYC consecutive
// supervised cycles pass without an alive strobe.
module hb_deadline_ctr
  import esd_hb_pkg::*;
#(
  parameter int TASK_CYC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic alive,
  output logic miss
);

  localparam int W = clog2(TASK_CYC) + 1;

  logic [W-1:0] cnt_q;
  logic         active;

  // A strobe, a disabled task or the clear input all restart the deadline;
  // a strobe on the deadline cycle therefore suppresses the miss.
  assign active = en && !clr && !alive;
  assign miss   = active && (cnt_q == W'(TASK_CYC - 1));

  // Count supervised cycles since the last restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt_q <= '0;
    else if (!active || miss) cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/esd_heartbeat_master.sv
// Supervised-side heartbeat master for the ESD controller: kicks the watchdog
// while all enabled host tasks are alive, and sequences ACK-based recovery
// after a controller shutdown.
module esd_heartbeat_master
  import esd_hb_pkg::*;
#(
  parameter int CLK_HZ        = 24000000,
  parameter int N_TASKS       = 4,
  parameter int KICK_MS       = 100,
  parameter int KICK_HIGH_CYC = 16,
  parameter int TASK_MS       = 250,
  parameter int ACK_LOW_MS    = 60,
  parameter int RELEASE_MS    = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [N_TASKS-1:0] task_en_i,
  input  logic [N_TASKS-1:0] task_alive_i,
  input  logic               shutdown_i,
  input  logic               estop_clear_i,
  input  logic               recover_req_i,
  output logic               wdg_kick_o,
  output logic               ack_n_o,
  output logic [STATE_W-1:0] state_o,
  output logic               fault_o,
  output logic [N_TASKS-1:0] miss_mask_o,
  output logic               ack_fail_o
);

  localparam int KICK_CYC    = ms_to_cyc(CLK_HZ, KICK_MS);
  localparam int TASK_CYC    = ms_to_cyc(CLK_HZ, TASK_MS);
  localparam int ACK_LOW_CYC = ms_to_cyc(CLK_HZ, ACK_LOW_MS);
  localparam int RELEASE_CYC = ms_to_cyc(CLK_HZ, RELEASE_MS);
  localparam int SEQ_CYC     = (ACK_LOW_CYC > RELEASE_CYC) ? ACK_LOW_CYC : RELEASE_CYC;
  localparam int KICK_W      = clog2(KICK_CYC) + 1;
  localparam int SEQ_W       = clog2(SEQ_CYC) + 1;

  hb_state_e          state_q, state_d;
  logic [1:0]         sync_q;
  logic               sd_s;
  logic [KICK_W-1:0]  kick_cnt_q;
  logic [SEQ_W-1:0]   seq_cnt_q;
  logic [N_TASKS-1:0] miss_vec;
  logic [N_TASKS-1:0] miss_mask_q;
  logic               fault_q, ack_fail_q;
  logic               set_fault, set_ack_fail, clr_flags;
  logic               in_run;

  assign in_run = (state_q == ST_RUN);
  assign sd_s   = sync_q[1];

  // Two-flop synchroniser for the controller shutdown line; resets to "shut down".
  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], shutdown_i};
  end

  // One deadline counter per supervised task; cleared whenever not in RUN.
  for (genvar i = 0; i < N_TASKS; i++) begin : g_task
    hb_deadline_ctr #(.TASK_CYC(TASK_CYC)) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (task_en_i[i]),
      .clr   (!in_run),
      .alive (task_alive_i[i]),
      .miss  (miss_vec[i])
    );
  end

  // Next-state logic and flag requests.
  // NOTE: every signal gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    set_fault    = 1'b0;
    set_ack_fail = 1'b0;
    clr_flags    = 1'b0;
    unique case (state_q)
      ST_IDLE: if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        set_fault = |miss_vec;
        if (sd_s)           state_d = ST_SHUTDOWN;
        else if (|miss_vec) state_d = ST_STARVE;
      end
      ST_STARVE:   if (sd_s) state_d = ST_SHUTDOWN;
      ST_SHUTDOWN: if (recover_req_i && estop_clear_i) state_d = ST_ACK_LOW;
      ST_ACK_LOW:  if (seq_cnt_q == SEQ_W'(ACK_LOW_CYC - 1)) state_d = ST_ACK_WAIT;
      ST_ACK_WAIT: begin
        if (!sd_s) begin
          state_d   = ST_RUN;
          clr_flags = 1'b1;
        end else if (seq_cnt_q == SEQ_W'(RELEASE_CYC - 1)) begin
          state_d      = ST_SHUTDOWN;
          set_ack_fail = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Kick period counter: restarts on entry to a kicking state, held at 0 elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      kick_cnt_q <= '0;
    else if (kick_active(state_d) && (state_d == state_q))
      kick_cnt_q <= (kick_cnt_q == KICK_W'(KICK_CYC - 1)) ? '0 : kick_cnt_q + 1'b1;
    else
      kick_cnt_q <= '0;
  end

  // Time spent in ACK_LOW / ACK_WAIT, restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        seq_cnt_q <= '0;
    else if (state_d != state_q)    seq_cnt_q <= '0;
    else if (state_q == ST_ACK_LOW ||
             state_q == ST_ACK_WAIT) seq_cnt_q <= seq_cnt_q + 1'b1;
    else                            seq_cnt_q <= '0;
  end

  // Sticky fault, miss mask and ACK-failure flags; cleared on successful recovery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q     <= 1'b0;
      miss_mask_q <= '0;
      ack_fail_q  <= 1'b0;
    end else if (clr_flags) begin
      fault_q     <= 1'b0;
      miss_mask_q <= '0;
      ack_fail_q  <= 1'b0;
    end else begin
      if (set_fault)    fault_q    <= 1'b1;
      if (set_ack_fail) ack_fail_q <= 1'b1;
      miss_mask_q <= miss_mask_q | miss_vec;
    end
  end

  // Outputs decode registered state so reset forces them at once.
  assign wdg_kick_o  = kick_active(state_q) && (kick_cnt_q < KICK_W'(KICK_HIGH_CYC));
  assign ack_n_o     = (state_q != ST_ACK_LOW);
  assign state_o     = state_q;
  assign fault_o     = fault_q;
  assign miss_mask_o = miss_mask_q;
  assign ack_fail_o  = ack_fail_q;

endmodule

// File: tb/tb_esd_heartbeat_master.sv
// Self-checking bench for esd_heartbeat_master: directed recovery scenarios plus
// a random soak, all compared every cycle against a timestamp-based model.
module tb_esd_heartbeat_master;

  localparam int CLK_HZ        = 1000;
  localparam int N_TASKS       = 2;
  localparam int KICK_MS       = 10;
  localparam int KICK_HIGH_CYC = 2;
  localparam int TASK_MS       = 25;
  localparam int ACK_LOW_MS    = 5;
  localparam int RELEASE_MS    = 20;

  // One cycle per millisecond at CLK_HZ = 1000.
  localparam int KICK_CYC    = KICK_MS;
  localparam int TASK_CYC    = TASK_MS;
  localparam int ACK_LOW_CYC = ACK_LOW_MS;
  localparam int RELEASE_CYC = RELEASE_MS;

  localparam int S_IDLE = 0, S_RUN = 1, S_STARVE = 2, S_SHUTDOWN = 3,
                 S_ACK_LOW = 4, S_ACK_WAIT = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start_i, shutdown_i, estop_clear_i, recover_req_i;
  logic [N_TASKS-1:0] task_en_i, task_alive_i;
  logic               wdg_kick_o, ack_n_o, fault_o, ack_fail_o;
  logic [2:0]         state_o;
  logic [N_TASKS-1:0] miss_mask_o;

  always #5 clk = ~clk;

  esd_heartbeat_master #(
    .CLK_HZ(CLK_HZ), .N_TASKS(N_TASKS), .KICK_MS(KICK_MS),
    .KICK_HIGH_CYC(KICK_HIGH_CYC), .TASK_MS(TASK_MS),
    .ACK_LOW_MS(ACK_LOW_MS), .RELEASE_MS(RELEASE_MS)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .task_en_i(task_en_i),
    .task_alive_i(task_alive_i), .shutdown_i(shutdown_i),
    .estop_clear_i(estop_clear_i), .recover_req_i(recover_req_i),
    .wdg_kick_o(wdg_kick_o), .ack_n_o(ack_n_o), .state_o(state_o),
    .fault_o(fault_o), .miss_mask_o(miss_mask_o), .ack_fail_o(ack_fail_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state plus the cycle it was entered, and per task the last
  // cycle at which its deadline restarted. Shutdown is seen through a 2-deep delay line.
  int                 cyc = 0;
  int                 m_state, m_entry;
  int                 m_last [N_TASKS];
  logic               m_fault, m_fail;
  logic [N_TASKS-1:0] m_mask;
  logic               sd_q [$];
  int                 cd [N_TASKS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_entry = cyc;
    m_fault = 1'b0;
    m_fail  = 1'b0;
    m_mask  = '0;
    sd_q    = '{1'b1, 1'b1};
    for (int i = 0; i < N_TASKS; i++) m_last[i] = cyc;
  endtask

  // Advance the model by one clock using the inputs applied this cycle.
  task automatic model_step();
    logic               sd;
    logic [N_TASKS-1:0] nm;
    int                 nxt;
    sd = sd_q.pop_front();
    sd_q.push_back(shutdown_i);
    nm = '0;
    for (int i = 0; i < N_TASKS; i++) begin
      if (m_state == S_RUN && task_en_i[i] && !task_alive_i[i]) begin
        if (cyc - m_last[i] == TASK_CYC) begin
          nm[i]     = 1'b1;
          m_last[i] = cyc;
        end
      end else begin
        m_last[i] = cyc;
      end
    end
    nxt = m_state;
    case (m_state)
      S_IDLE:     if (start_i) nxt = S_RUN;
      S_RUN: begin
        m_mask = m_mask | nm;
        if (nm != '0) m_fault = 1'b1;
        if (sd)              nxt = S_SHUTDOWN;
        else if (nm != '0)   nxt = S_STARVE;
      end
      S_STARVE:   if (sd) nxt = S_SHUTDOWN;
      S_SHUTDOWN: if (recover_req_i && estop_clear_i) nxt = S_ACK_LOW;
      S_ACK_LOW:  if (cyc - m_entry + 1 == ACK_LOW_CYC) nxt = S_ACK_WAIT;
      S_ACK_WAIT: begin
        if (!sd) begin
          nxt     = S_RUN;
          m_fault = 1'b0;
          m_fail  = 1'b0;
          m_mask  = '0;
        end else if (cyc - m_entry + 1 == RELEASE_CYC) begin
          nxt    = S_SHUTDOWN;
          m_fail = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (nxt != m_state) m_entry = cyc + 1;
    m_state = nxt;
    cyc++;
  endtask

  // Compare all outputs mid-cycle, step the model, then clear 1-cycle pulses.
  task automatic tick();
    logic ek;
    @(negedge clk);
    ek = (m_state == S_RUN || m_state == S_ACK_WAIT) &&
         (((cyc - m_entry) % KICK_CYC) < KICK_HIGH_CYC);
    check("state",     32'(state_o),     32'(m_state));
    check("kick",      32'(wdg_kick_o),  32'(ek));
    check("ack_n",     32'(ack_n_o),     32'(m_state != S_ACK_LOW));
    check("fault",     32'(fault_o),     32'(m_fault));
    check("miss_mask", 32'(miss_mask_o), 32'(m_mask));
    check("ack_fail",  32'(ack_fail_o),  32'(m_fail));
    model_step();
    @(posedge clk);
    #1;
    start_i       = 1'b0;
    recover_req_i = 1'b0;
    task_alive_i  = '0;
  endtask

  // Run n cycles; tasks in 'healthy' strobe at random intervals well inside the deadline.
  task automatic run(input int n, input logic [N_TASKS-1:0] healthy);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N_TASKS; i++) begin
        if (healthy[i]) begin
          if (cd[i] == 0) begin
            task_alive_i[i] = 1'b1;
            cd[i] = int'($urandom_range(4, 20));
          end else begin
            cd[i]--;
          end
        end
      end
      tick();
    end
  endtask

  // Assert reset between edges and check outputs respond without a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_state",    32'(state_o),     32'(S_IDLE));
    check("rst_kick",     32'(wdg_kick_o),  32'(0));
    check("rst_ack_n",    32'(ack_n_o),     32'(1));
    check("rst_fault",    32'(fault_o),     32'(0));
    check("rst_mask",     32'(miss_mask_o), 32'(0));
    check("rst_ack_fail", 32'(ack_fail_o),  32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int   low_cnt;
    logic prev_ack, kick_after;
    start_i       = 1'b0;
    shutdown_i    = 1'b0;
    estop_clear_i = 1'b1;
    recover_req_i = 1'b0;
    task_en_i     = 2'b11;
    task_alive_i  = '0;
    for (int i = 0; i < N_TASKS; i++) cd[i] = 0;

    // 1. Reset, start, both tasks healthy: periodic kicks, no fault.
    do_reset();
    run(5, 2'b11);
    start_i = 1'b1;
    run(1, 2'b11);
    check("run_entry_state", 32'(state_o), 32'(S_RUN));
    check("run_entry_kick",  32'(wdg_kick_o), 32'(1));
    run(60, 2'b11);
    start_i = 1'b1;                       // ignored outside IDLE
    run(20, 2'b11);
    check("healthy_fault", 32'(fault_o), 32'(0));

    // 2. Task 1 goes silent: miss, STARVE, then controller shutdown.
    for (int k = 0; k < 40 && !fault_o; k++) run(1, 2'b01);
    check("miss_fault", 32'(fault_o),     32'(1));
    check("miss_mask",  32'(miss_mask_o), 32'(2'b10));
    check("miss_state", 32'(state_o),     32'(S_STARVE));
    run(4, 2'b01);
    check("starve_kick", 32'(wdg_kick_o), 32'(0));
    shutdown_i = 1'b1;
    run(1, 2'b01);
    check("sync_latency", 32'(state_o), 32'(S_STARVE));
    for (int k = 0; k < 4 && state_o != 3'(S_SHUTDOWN); k++) run(1, 2'b01);
    check("shutdown_state", 32'(state_o), 32'(S_SHUTDOWN));

    // 3. Recovery request dropped while E-STOP engaged, then accepted.
    estop_clear_i = 1'b0;
    recover_req_i = 1'b1;
    run(4, 2'b11);
    check("req_dropped", 32'(state_o), 32'(S_SHUTDOWN));
    estop_clear_i = 1'b1;
    recover_req_i = 1'b1;
    run(1, 2'b11);
    low_cnt    = 0;
    prev_ack   = 1'b1;
    kick_after = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!ack_n_o) low_cnt++;
      if (!prev_ack && ack_n_o) kick_after = wdg_kick_o;
      prev_ack = ack_n_o;
      run(1, 2'b11);
    end
    check("ack_low_cycles", 32'(low_cnt),    32'(ACK_LOW_CYC));
    check("kick_after_ack", 32'(kick_after), 32'(1));

    // 4. Shutdown never releases: ACK_WAIT times out.
    run(20, 2'b11);
    check("release_timeout_state", 32'(state_o),    32'(S_SHUTDOWN));
    check("release_timeout_flag",  32'(ack_fail_o), 32'(1));

    // 5. Retry; shutdown drops 8 cycles into ACK_WAIT.
    recover_req_i = 1'b1;
    run(1, 2'b11);
    run(ACK_LOW_CYC + 8, 2'b11);
    shutdown_i = 1'b0;
    run(6, 2'b11);
    check("recovered_state", 32'(state_o),     32'(S_RUN));
    check("recovered_fault", 32'(fault_o),     32'(0));
    check("recovered_mask",  32'(miss_mask_o), 32'(0));
    check("recovered_fail",  32'(ack_fail_o),  32'(0));
    // Strobe exactly on the deadline cycle: no miss.
    for (int k = 0; k < 80; k++) begin
      task_alive_i[0] = (k % TASK_CYC == 0);
      task_alive_i[1] = (k % 10 == 0);
      tick();
    end
    check("deadline_edge_fault", 32'(fault_o), 32'(0));

    // 6. Reset in the middle of ACK_LOW, then restart.
    shutdown_i = 1'b1;
    run(4, 2'b11);
    recover_req_i = 1'b1;
    run(1, 2'b11);
    run(2, 2'b11);
    check("in_ack_low", 32'(ack_n_o), 32'(0));
    #2;
    shutdown_i = 1'b0;
    do_reset();
    run(4, 2'b11);
    start_i = 1'b1;
    run(1, 2'b11);
    check("restart_kick", 32'(wdg_kick_o), 32'(1));
    run(30, 2'b11);

    // 7. Random soak against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0)  start_i       = 1'b1;
      if ($urandom_range(0, 7) == 0)   recover_req_i = 1'b1;
      if ($urandom_range(0, 29) == 0)  estop_clear_i = !estop_clear_i;
      if ($urandom_range(0, 39) == 0)  shutdown_i    = !shutdown_i;
      for (int i = 0; i < N_TASKS; i++) begin
        if ($urandom_range(0, 149) == 0) task_en_i[i] = !task_en_i[i];
        if ($urandom_range(0, 11) == 0)  task_alive_i[i] = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
